// File: rtl/frame_store_responder.sv
// Frame-store bus responder: one word transfer at a time onto a single-port SRAM
// without byte enables; partial-lane writes become read-modify-write.
module frame_store_responder #(
    parameter int ADDR_W = 18,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              de_req,
    output logic              de_ack,
    input  logic [ADDR_W-1:0] de_addr,
    input  logic [3:0]        de_nbyte,
    input  logic              de_rnw,
    input  logic [31:0]       de_w_data,
    output logic [31:0]       de_r_data,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, ACK} state_t;

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        nbyte_q;
    logic              rnw_q;
    logic [31:0]       wdata_q;
    logic [2:0]        lat_cnt, lat_cnt_nxt;
    logic              de_ack_nxt, mem_cs_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [31:0]       mem_wdata_nxt, de_r_data_nxt;
    logic              accept, lat_done;

    // Lanes with nbyte bit low take the new data, the rest keep the SRAM contents.
    function automatic logic [31:0] merge_bytes(input logic [31:0] wd,
                                                input logic [31:0] rd,
                                                input logic [3:0]  nb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++)
            m[8*i +: 8] = nb[i] ? rd[8*i +: 8] : wd[8*i +: 8];
        return m;
    endfunction

    assign accept   = (state == IDLE) && de_req;
    assign lat_done = (lat_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            de_ack    <= 1'b0;
            de_r_data <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            de_ack    <= de_ack_nxt;
            de_r_data <= de_r_data_nxt;
            mem_cs    <= mem_cs_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            lat_cnt   <= lat_cnt_nxt;
        end
    end

    // Request fields are frozen at accept so later bus changes cannot leak in.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= de_addr;
            nbyte_q <= de_nbyte;
            rnw_q   <= de_rnw;
            wdata_q <= de_w_data;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (de_req) begin
                    if (de_rnw)                  state_nxt = RD;
                    else if (de_nbyte == 4'b0000) state_nxt = WR;
                    else if (de_nbyte == 4'b1111) state_nxt = ACK;
                    else                          state_nxt = RD;
                end
            end
            RD:    state_nxt = RWAIT;
            RWAIT: if (lat_done) state_nxt = rnw_q ? ACK : WR;
            WR:    if (mem_cs) state_nxt = ACK;
            ACK:   if (de_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // WR and ACK are entered with their strobe low on the full-write and null-write
    // paths, so those strobes rise one edge later and every path keeps its latency.
    always_comb begin
        de_ack_nxt    = 1'b0;
        mem_cs_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        de_r_data_nxt = de_r_data;
        lat_cnt_nxt   = lat_cnt;
        case (state)
            IDLE: begin
                if (de_req) begin
                    mem_addr_nxt  = de_addr;
                    mem_wdata_nxt = de_w_data;
                    if (de_rnw || (de_nbyte != 4'b0000 && de_nbyte != 4'b1111))
                        mem_cs_nxt = 1'b1;
                end
            end
            RD: lat_cnt_nxt = '0;
            RWAIT: begin
                lat_cnt_nxt = lat_cnt + 3'd1;
                if (lat_done) begin
                    if (rnw_q) begin
                        de_ack_nxt    = 1'b1;
                        de_r_data_nxt = mem_rdata;
                    end else begin
                        mem_cs_nxt    = 1'b1;
                        mem_we_nxt    = 1'b1;
                        mem_addr_nxt  = addr_q;
                        mem_wdata_nxt = merge_bytes(wdata_q, mem_rdata, nbyte_q);
                    end
                end
            end
            WR: begin
                if (mem_cs) begin
                    de_ack_nxt = 1'b1;
                end else begin
                    mem_cs_nxt    = 1'b1;
                    mem_we_nxt    = 1'b1;
                    mem_addr_nxt  = addr_q;
                    mem_wdata_nxt = wdata_q;
                end
            end
            ACK: if (!de_ack) de_ack_nxt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_frame_store_responder.sv
// Bench for frame_store_responder: two instances (RD_LAT 1 and 3), each with its
// own SRAM model, driven by a vector table plus back-to-back and reset sequences.
module tb_frame_store_responder;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        req, ack, rnw_s, cs, we;
    logic [1:0][17:0]  addr, maddr;
    logic [1:0][3:0]   nbyte;
    logic [1:0][31:0]  wdata, r_data, mwdata, mrdata;

    logic [31:0] mem  [2][1024];
    logic [31:0] pipe [2][4];
    logic        pre_en;
    int          pre_u;
    logic [9:0]  pre_a;
    logic [31:0] pre_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    frame_store_responder #(.ADDR_W(18), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .de_req(req[0]), .de_ack(ack[0]),
        .de_addr(addr[0]), .de_nbyte(nbyte[0]), .de_rnw(rnw_s[0]),
        .de_w_data(wdata[0]), .de_r_data(r_data[0]), .mem_cs(cs[0]),
        .mem_we(we[0]), .mem_addr(maddr[0]), .mem_wdata(mwdata[0]),
        .mem_rdata(mrdata[0])
    );

    frame_store_responder #(.ADDR_W(18), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .de_req(req[1]), .de_ack(ack[1]),
        .de_addr(addr[1]), .de_nbyte(nbyte[1]), .de_rnw(rnw_s[1]),
        .de_w_data(wdata[1]), .de_r_data(r_data[1]), .mem_cs(cs[1]),
        .mem_we(we[1]), .mem_addr(maddr[1]), .mem_wdata(mwdata[1]),
        .mem_rdata(mrdata[1])
    );

    // SRAM models: read data appears RD_LAT edges after the chip-select edge.
    assign mrdata[0] = pipe[0][0];
    assign mrdata[1] = pipe[1][2];

    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (cs[u] && we[u]) mem[u][maddr[u][9:0]] <= mwdata[u];
            pipe[u][0] <= (cs[u] && !we[u]) ? mem[u][maddr[u][9:0]] : 32'hBAD0_0000;
            for (int k = 1; k < 4; k++) pipe[u][k] <= pipe[u][k-1];
        end
        if (pre_en) mem[pre_u][pre_a] <= pre_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input int u, input logic [17:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_u = u; pre_a = a[9:0]; pre_d = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // One transfer; k counts edges from the accept edge E0 (k = 0).
    task automatic run_xfer(input int u, input logic r, input logic [17:0] a,
                            input logic [3:0] nb, input logic [31:0] wd,
                            output int ack_at, output int acks, output int nrd,
                            output int nwr, output logic [31:0] rd);
        ack_at = -1; acks = 0; nrd = 0; nwr = 0; rd = '0;
        @(negedge clk);
        req[u] = 1'b1; rnw_s[u] = r; addr[u] = a; nbyte[u] = nb; wdata[u] = wd;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                req[u] = 1'b0; rnw_s[u] = ~r; addr[u] = ~a; nbyte[u] = ~nb; wdata[u] = ~wd;
            end
            if (cs[u]) begin
                if (we[u]) nwr++;
                else       nrd++;
            end
            if (ack[u]) begin
                acks++;
                if (ack_at < 0) begin
                    ack_at = k;
                    rd = r_data[u];
                end
            end
        end
    endtask

    typedef struct {
        int          u;
        logic        r;
        logic [17:0] a;
        logic [3:0]  nb;
        logic [31:0] wd;
        logic [31:0] pre;
        int          ack;
        int          nrd;
        int          nwr;
        logic [31:0] mem;
    } vec_t;

    initial begin
        vec_t        tv[8];
        int          ack_at, acks, nrd, nwr, idx, last, bad;
        int          wcnt[4];
        logic [31:0] rd;

        tv[0] = '{0, 1'b1, 18'h00010, 4'h0, 32'h0,        32'hDEADBEEF, 2, 1, 0, 32'hDEADBEEF};
        tv[1] = '{0, 1'b0, 18'h00200, 4'h0, 32'h12345678, 32'h00000000, 2, 0, 1, 32'h12345678};
        tv[2] = '{1, 1'b0, 18'h00005, 4'hD, 32'h0000EE00, 32'hAABBCCDD, 5, 1, 1, 32'hAABBEEDD};
        tv[3] = '{0, 1'b0, 18'h00020, 4'hF, 32'hFFFFFFFF, 32'h55AA55AA, 1, 0, 0, 32'h55AA55AA};
        tv[4] = '{1, 1'b1, 18'h00030, 4'h0, 32'h0,        32'h01020304, 4, 1, 0, 32'h01020304};
        tv[5] = '{0, 1'b0, 18'h00040, 4'h6, 32'hA0B0C0D0, 32'h11223344, 3, 1, 1, 32'hA02233D0};
        tv[6] = '{1, 1'b0, 18'h00050, 4'h0, 32'hCAFEF00D, 32'h00000000, 2, 0, 1, 32'hCAFEF00D};
        tv[7] = '{1, 1'b0, 18'h00060, 4'hE, 32'h123456FF, 32'h00000000, 5, 1, 1, 32'h000000FF};

        rst_n = 1'b0; req = '0; rnw_s = '0; addr = '0; nbyte = '0; wdata = '0;
        pre_en = 1'b0; pre_u = 0; pre_a = '0; pre_d = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("reset u%0d ack", u),      32'(ack[u]),    32'h0);
            chk($sformatf("reset u%0d cs", u),       32'(cs[u]),     32'h0);
            chk($sformatf("reset u%0d we", u),       32'(we[u]),     32'h0);
            chk($sformatf("reset u%0d r_data", u),   r_data[u],      32'h0);
            chk($sformatf("reset u%0d mem_addr", u), 32'(maddr[u]),  32'h0);
            chk($sformatf("reset u%0d wdata", u),    mwdata[u],      32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            preload(tv[i].u, tv[i].a, tv[i].pre);
            run_xfer(tv[i].u, tv[i].r, tv[i].a, tv[i].nb, tv[i].wd, ack_at, acks, nrd, nwr, rd);
            chk($sformatf("v%0d ack_at", i), 32'(ack_at), 32'(tv[i].ack));
            chk($sformatf("v%0d ack_count", i), 32'(acks), 32'd1);
            chk($sformatf("v%0d read_cycles", i), 32'(nrd), 32'(tv[i].nrd));
            chk($sformatf("v%0d write_cycles", i), 32'(nwr), 32'(tv[i].nwr));
            chk($sformatf("v%0d sram", i), mem[tv[i].u][tv[i].a[9:0]], tv[i].mem);
            if (tv[i].r) chk($sformatf("v%0d r_data", i), rd, tv[i].mem);
        end

        // Back-to-back full writes with de_req held; initiator advances on each ack.
        for (int j = 0; j < 4; j++) wcnt[j] = 0;
        idx = 0; last = -1;
        @(negedge clk);
        req[0] = 1'b1; rnw_s[0] = 1'b0; nbyte[0] = 4'h0; addr[0] = 18'h100; wdata[0] = 32'hB0000000;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (cs[0] && we[0] && maddr[0] >= 18'h100 && maddr[0] <= 18'h103)
                wcnt[int'(maddr[0] - 18'h100)]++;
            if (ack[0]) begin
                if (idx > 0) chk($sformatf("b2b gap %0d", idx), 32'(k - last), 32'd4);
                last = k;
                idx++;
                if (idx < 4) begin
                    addr[0]  = 18'h100 + 18'(idx);
                    wdata[0] = 32'hB0000000 + 32'(idx);
                end else begin
                    req[0] = 1'b0;
                end
            end
        end
        req[0] = 1'b0;
        chk("b2b ack_count", 32'(idx), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("b2b writes a%0d", j), 32'(wcnt[j]), 32'd1);
            chk($sformatf("b2b sram a%0d", j), mem[0][10'h100 + 10'(j)], 32'hB0000000 + 32'(j));
        end

        // Reset while the RD_LAT=3 instance waits in RWAIT of a read-modify-write.
        preload(1, 18'h70, 32'h77777777);
        @(negedge clk);
        req[1] = 1'b1; rnw_s[1] = 1'b0; addr[1] = 18'h70; nbyte[1] = 4'hC; wdata[1] = 32'h0000ABCD;
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst mid cs", 32'(cs[1]), 32'h0);
        chk("rst mid we", 32'(we[1]), 32'h0);
        chk("rst mid ack", 32'(ack[1]), 32'h0);
        chk("rst mid r_data", r_data[1], 32'h0);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (cs[1] || ack[1]) bad++;
        end
        chk("rst quiet after", 32'(bad), 32'h0);
        chk("rst sram kept", mem[1][10'h070], 32'h77777777);
        run_xfer(1, 1'b1, 18'h70, 4'h0, 32'h0, ack_at, acks, nrd, nwr, rd);
        chk("post-rst ack_at", 32'(ack_at), 32'd4);
        chk("post-rst ack_count", 32'(acks), 32'd1);
        chk("post-rst r_data", rd, 32'h77777777);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_store_responder.md
Name: frame_store_responder

Overview:
- Memory-side responder for the drawing-engine frame-store bus (de_req/de_ack/de_addr/de_nbyte/de_rnw/de_w_data/de_r_data).
- Accepts one word transfer at a time from the dithering/drawing engine and performs it on a single-port synchronous SRAM that has no byte enables.
- Partial-byte writes are implemented as read-modify-write. Full-word writes and reads go straight through.
- Sits between mydithering-class initiators and the frame-buffer SRAM.

Parameters:
ADDR_W, 18, word-address width of de_addr and mem_addr
RD_LAT, 1, SRAM read latency in cycles from the mem_cs cycle to mem_rdata valid; legal range 1..4

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst_n  in  1  reset, synchronous, active-low
de_req  in  1  transfer request from the initiator, level
de_ack  out  1  one-cycle completion pulse
de_addr  in  ADDR_W  word address
de_nbyte  in  4  byte-lane mask, active-low; bit i = 0 means byte i (bits 8i+7:8i) is written
de_rnw  in  1  1 = read, 0 = write
de_w_data  in  32  write data
de_r_data  out  32  read data, valid while de_ack = 1
mem_cs  out  1  SRAM chip select, one-cycle strobe per access
mem_we  out  1  SRAM write enable, qualified by mem_cs
mem_addr  out  ADDR_W  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data

Behaviour:
- Reset: when rst_n = 0 at a rising edge, the following are forced regardless of state:
  - state = IDLE; de_ack = 0; de_r_data = 0.
  - mem_cs = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; latency counter = 0.
  - Any in-flight read data is discarded and no ack is issued for it.
- All outputs are registered.
- States: IDLE, RD, RWAIT, WR, ACK.
- IDLE: at an edge with de_req = 1, capture de_addr, de_nbyte, de_rnw and de_w_data into internal registers. Call this edge E0. Then branch:
  - rnw = 1 -> RD.
  - rnw = 0 and nbyte = 4'b0000 -> WR (full word, no read).
  - rnw = 0 and nbyte = 4'b1111 -> ACK directly. No SRAM access; de_ack rises at E0+1.
  - rnw = 0, any other mask -> RD (read phase of the read-modify-write).
- RD: mem_cs = 1, mem_we = 0, mem_addr = captured address for exactly one cycle (the cycle after E0). Then go to RWAIT.
- RWAIT: count RD_LAT cycles. mem_rdata is sampled at edge E0+1+RD_LAT.
  - Read transfer: de_r_data is loaded with mem_rdata and de_ack = 1 at that same edge (state ACK). Read latency from accept edge to ack = 1+RD_LAT edges.
  - RMW transfer: build the merged word. For each byte i: byte i = de_w_data byte i if nbyte[i] = 0, else the mem_rdata byte. Go to WR.
- WR: mem_cs = 1, mem_we = 1, mem_addr = captured address, mem_wdata = full or merged word, for exactly one cycle. At the following edge, de_ack = 1 and mem_cs/mem_we = 0 (state ACK).
  - Full write: ack at E0+2.
  - RMW: ack at E0+2+RD_LAT.
- ACK: de_ack held for exactly one cycle; de_r_data holds its value for that cycle.
  - At the next edge: de_ack = 0 and state = IDLE, with de_req ignored on that edge.
  - The earliest next accept is therefore 2 edges after the ack edge. This gives the initiator one full cycle to update de_addr after seeing de_ack.
- de_r_data keeps its last value outside ACK. Its value after a write is don't-care but must be stable.
- De-assertion of de_req after accept does not abort the transfer. The transfer completes and the ack is still pulsed.
- Input changes on de_addr, de_nbyte, de_rnw and de_w_data after E0 have no effect on the transfer in progress.
- At most one SRAM access per cycle. mem_cs is never asserted in IDLE or ACK.

Test Plan:
- Read, RD_LAT=1: SRAM[0x00010] = 0xDEADBEEF; de_req=1, rnw=1, addr=0x00010 -> mem_cs pulse 1 cycle after accept with mem_we=0; de_ack pulse at E0+2 with de_r_data = 0xDEADBEEF; single pulse only.
- Full write: addr=0x00200, nbyte=0000, w_data=0x12345678 -> exactly one mem_cs cycle with mem_we=1 and no read; de_ack at E0+2; SRAM[0x00200] = 0x12345678.
- RMW, RD_LAT=3: SRAM[5] = 0xAABBCCDD; nbyte=1101, w_data=0x0000EE00 -> one read cycle, then one write of 0xAABBEEDD; de_ack at E0+5.
- Null write nbyte=1111 -> no mem_cs at all; de_ack at E0+1; SRAM unchanged.
- Back-to-back with de_req held high over 4 consecutive addresses, initiator updating addr on ack -> 4 acks; no accept on the edge right after each ack; each address written once with the correct data.
- rst_n=0 during RWAIT of an RMW -> next edge: mem_cs/mem_we/de_ack = 0, state IDLE; no SRAM write occurs and no ack pulse appears; a later request completes normally.
